lc3_kbd_uart_rx: RTL and testbench

Serial receive front end for the LC-3 keyboard device. It deserialises 8N1 UART frames from the host into an 8-bit character and holds it as the KBDR byte. It also maintains the KBSR ready bit. The `kbdr` output feeds the 8-to-16 zero extender that forms the 16-bit memory-mapped read value. The `ready` output drives KBSR[15].

---
 rtl/lc3_kbd_uart_rx.sv | 130 +++++++++++++
 tb/tb_lc3_kbd_uart_rx.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_kbd_uart_rx.sv
// LC-3 keyboard serial receive front end.
// Deserialises 8N1 frames into KBDR and maintains KBSR ready.
module lc3_kbd_uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       rd_kbdr,
    output logic [7:0] kbdr,
    output logic       ready,
    output logic       overrun,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          rx_m, rx_s;
    logic          commit, ferr_set;

    // Two-flop synchroniser for the asynchronous serial line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // Receiver state, bit timer, bit index and shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shreg <= shreg_n;
        end
    end

    // Next-state logic; mid-bit sampling of the synchronised line.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt + CW'(1);
        idx_n    = idx;
        shreg_n  = shreg;
        commit   = 1'b0;
        ferr_set = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                idx_n = '0;
                if (!rx_s) state_n = START;
            end
            START: begin
                if (cnt == HALF) begin
                    cnt_n   = '0;
                    state_n = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    shreg_n = {rx_s, shreg[7:1]};
                    idx_n   = idx + 3'd1;
                    if (idx == 3'd7) state_n = STOP;
                end
            end
            STOP: begin
                if (cnt == LAST) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        commit  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_n  = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                cnt_n = '0;
                if (rx_s) state_n = IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    // KBDR/KBSR registers; a commit outranks a same-cycle read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kbdr      <= '0;
            ready     <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (commit) kbdr <= shreg;
            if (commit) ready <= 1'b1;
            else if (rd_kbdr) ready <= 1'b0;
            if (commit && ready && !rd_kbdr) overrun <= 1'b1;
            else if (rd_kbdr) overrun <= 1'b0;
            if (ferr_set) frame_err <= 1'b1;
            else if (rd_kbdr) frame_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lc3_kbd_uart_rx.sv
// Self-checking bench for lc3_kbd_uart_rx.
// Frame-level model with scheduled commit events.
module tb_lc3_kbd_uart_rx;

    localparam int CPB = 16;
    localparam int LAT = 3 + CPB / 2 + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       rd_kbdr;
    logic [7:0] kbdr;
    logic       ready;
    logic       overrun;
    logic       frame_err;

    int  cyc = 0;
    int  nchk = 0;
    int  npass = 0;
    bit  rand_en = 0;

    logic [7:0] m_kbdr = 8'h00;
    logic       m_rdy = 1'b0;
    logic       m_ovr = 1'b0;
    logic       m_ferr = 1'b0;

    typedef struct {
        int         c;
        logic [7:0] b;
        bit         ok;
    } ev_t;
    ev_t evq[$];

    lc3_kbd_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx(rx),
        .rd_kbdr(rd_kbdr),
        .kbdr(kbdr),
        .ready(ready),
        .overrun(overrun),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input int unsigned a,
                       input int unsigned e);
        nchk++;
        if (a == e) npass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)",
                      n, a, e, $time);
    endtask

    // Model: a committed byte lands LAT edges after the start edge.
    always @(posedge clk or negedge rst_n) begin : model
        bit         hit;
        bit         ok;
        logic [7:0] b;
        if (!rst_n) begin
            m_kbdr = 8'h00;
            m_rdy  = 1'b0;
            m_ovr  = 1'b0;
            m_ferr = 1'b0;
            evq.delete();
        end else begin
            hit = 0;
            ok  = 0;
            b   = 8'h00;
            if (evq.size() > 0 && evq[0].c == cyc + 1) begin
                hit = 1;
                ok  = evq[0].ok;
                b   = evq[0].b;
                void'(evq.pop_front());
            end
            if (hit && ok) begin
                if (m_rdy && !rd_kbdr) m_ovr = 1'b1;
                else if (rd_kbdr) m_ovr = 1'b0;
                m_rdy  = 1'b1;
                m_kbdr = b;
            end else if (rd_kbdr) begin
                m_rdy = 1'b0;
                m_ovr = 1'b0;
            end
            if (hit && !ok) m_ferr = 1'b1;
            else if (rd_kbdr) m_ferr = 1'b0;
        end
    end

    always @(negedge clk)
        chk("outputs", {kbdr, ready, overrun, frame_err},
            {m_kbdr, m_rdy, m_ovr, m_ferr});

    always begin
        @(posedge clk);
        #1;
        if (rand_en) rd_kbdr = ($urandom_range(0, 30) == 0);
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            rx = 1'b1;
        end
    endtask

    task automatic pulse_rd();
        @(posedge clk);
        #1 rd_kbdr = 1'b1;
        @(posedge clk);
        #1 rd_kbdr = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit ok,
                        input bit rdc, input int abort_bit);
        logic [9:0] fr;
        int k;
        fr = {ok, b, 1'b0};
        @(posedge clk);
        #1;
        k = cyc;
        evq.push_back('{k + LAT, b, ok});
        for (int i = 0; i < 10 * CPB; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            rx = fr[i / CPB];
            if (rdc) rd_kbdr = (i == LAT - 1);
            if (abort_bit >= 0 && i == CPB * (1 + abort_bit) + CPB / 2) begin
                rst_n = 1'b0;
                #1;
                chk("abort_reset", {kbdr, ready, overrun, frame_err}, 0);
                @(posedge clk);
                #1;
                rx = 1'b1;
                rst_n = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        logic [7:0] b;
        bit ok;
        rx = 1'b1;
        rd_kbdr = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset", {kbdr, ready, overrun, frame_err}, 0);
        idle(1000);
        chk("idle1000", {kbdr, ready, overrun, frame_err}, 0);

        send(8'h41, 1, 0, -1);
        idle(2);
        chk("A_kbdr", kbdr, 8'h41);
        chk("A_ready", ready, 1);
        pulse_rd();
        chk("A_rd_ready", ready, 0);
        chk("A_rd_kbdr", kbdr, 8'h41);

        idle(10);
        send(8'h0D, 1, 0, -1);
        send(8'h7A, 1, 0, -1);
        idle(2);
        chk("ovr_kbdr", kbdr, 8'h7A);
        chk("ovr_flags", {ready, overrun}, 2'b11);
        pulse_rd();
        chk("ovr_clear", {ready, overrun}, 2'b00);

        idle(10);
        send(8'h55, 0, 0, -1);
        repeat (40 * CPB) @(posedge clk);
        #1;
        chk("ferr_flags", {frame_err, ready}, 2'b10);
        chk("ferr_kbdr", kbdr, 8'h7A);
        idle(32);
        send(8'h33, 1, 0, -1);
        idle(2);
        chk("after_break", {kbdr, ready}, {8'h33, 1'b1});

        @(posedge clk);
        #1 rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx = 1'b1;
        idle(200);
        chk("glitch", {kbdr, ready, overrun}, {8'h33, 2'b10});

        send(8'h99, 1, 1, -1);
        idle(2);
        chk("rd_commit", {kbdr, ready, overrun, frame_err},
            {8'h99, 3'b100});
        pulse_rd();
        idle(10);

        send(8'hFF, 1, 0, 4);
        idle(20);
        send(8'h12, 1, 0, -1);
        idle(2);
        chk("post_abort", {kbdr, ready}, {8'h12, 1'b1});

        rand_en = 1;
        for (int n = 0; n < 40; n++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(0, 7) != 0);
            send(b, ok, 0, -1);
            idle(ok ? $urandom_range(0, 20) : $urandom_range(8, 40));
        end
        rand_en = 0;
        @(posedge clk);
        #2 rd_kbdr = 1'b0;
        idle(20);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
